// File: rtl/pkt_add_pkg.sv
// Shared types for the add-offset / append-trailer packet stage.
// State encoding and the packed {len,k} configuration word.
package pkt_add_pkg;

   localparam int PKT_DW = 8;

   typedef enum logic [1:0] {
      IDLE,
      BODY,
      TRAILER
   } pkt_state_t;

   typedef struct packed {
      logic [PKT_DW-1:0] len;
      logic [PKT_DW-1:0] k;
   } pkt_cfg_t;

endpackage

// File: rtl/axis_pkt_add_trailer_out_reg.sv
// Single-entry AXI-Stream output register with valid/ready hold.
// Ports: load/ld_data/ld_last in, free out, m_tdata/m_tvalid/m_tlast/m_tready.
module axis_out_reg #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_last,
   output logic          free,
   output logic [DW-1:0] m_tdata,
   output logic          m_tvalid,
   output logic          m_tlast,
   input  logic          m_tready
);

   // Slot can take a new beat when empty or being drained this cycle.
   assign free = !m_tvalid || m_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
      end else if (load) begin
         m_tdata  <= ld_data;
         m_tlast  <= ld_last;
         m_tvalid <= 1'b1;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_pkt_add_trailer.sv
// Adds offset k to every byte, appends a sum trailer, checks packet length.
// Ports: s_* input stream, packet_config {len,k}, m_* output stream, pkt_err, pkt_count.
module axis_pkt_add_trailer
   import pkt_add_pkg::*;
#(
   parameter int DW = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] s_tdata,
   input  logic          s_tvalid,
   input  logic          s_tlast,
   output logic          s_tready,
   input  logic [2*DW-1:0] packet_config,
   output logic [DW-1:0] m_tdata,
   output logic          m_tvalid,
   output logic          m_tlast,
   input  logic          m_tready,
   output logic          pkt_err,
   output logic [CW-1:0] pkt_count
);

   pkt_state_t    state, state_nx;
   logic [DW-1:0] len_q, k_q, sum, beat_cnt;
   logic [DW-1:0] k_use, body_byte, ld_data;
   logic          out_free, accept, trl_go, load, ld_last;

   always_comb begin
      state_nx  = state;
      s_tready  = (state != TRAILER) && out_free;
      accept    = s_tvalid && s_tready;
      trl_go    = (state == TRAILER) && out_free;
      // First beat must use the incoming k, not the stale latched one.
      k_use     = (state == IDLE) ? packet_config[DW-1:0] : k_q;
      body_byte = s_tdata + k_use;
      load      = accept || trl_go;
      ld_data   = trl_go ? sum : body_byte;
      ld_last   = trl_go;
      unique case (state)
         IDLE:    if (accept) state_nx = s_tlast ? TRAILER : BODY;
         BODY:    if (accept && s_tlast) state_nx = TRAILER;
         TRAILER: if (out_free) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         len_q     <= '0;
         k_q       <= '0;
         sum       <= '0;
         beat_cnt  <= '0;
         pkt_count <= '0;
         pkt_err   <= 1'b0;
      end else begin
         state   <= state_nx;
         pkt_err <= 1'b0;
         if (accept && state == IDLE) begin
            len_q    <= packet_config[2*DW-1:DW];
            k_q      <= packet_config[DW-1:0];
            sum      <= body_byte;
            beat_cnt <= DW'(1);
         end else if (accept) begin
            sum <= sum + body_byte;
            if (beat_cnt != '1)
               beat_cnt <= beat_cnt + DW'(1);
         end
         if (trl_go) begin
            if (pkt_count != '1)
               pkt_count <= pkt_count + CW'(1);
            pkt_err <= (len_q != '0) && (beat_cnt != len_q);
         end
      end
   end

   axis_out_reg #(.DW(DW)) u_out (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .ld_data  (ld_data),
      .ld_last  (ld_last),
      .free     (out_free),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tready (m_tready)
   );

endmodule

// File: tb/tb_axis_pkt_add_trailer.sv
// Self-checking bench for axis_pkt_add_trailer.
// Packet-level model predicts every output beat, trailer, error pulse and count.
module tb_axis_pkt_add_trailer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tready;
   logic [15:0] packet_config;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_tready;
   logic        pkt_err;
   logic [15:0] pkt_count;

   always #5 clk = ~clk;

   axis_pkt_add_trailer #(.DW(8), .CW(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_tdata       (s_tdata),
      .s_tvalid      (s_tvalid),
      .s_tlast       (s_tlast),
      .s_tready      (s_tready),
      .packet_config (packet_config),
      .m_tdata       (m_tdata),
      .m_tvalid      (m_tvalid),
      .m_tlast       (m_tlast),
      .m_tready      (m_tready),
      .pkt_err       (pkt_err),
      .pkt_count     (pkt_count)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Packet-level model state
   logic [8:0] exp_q[$];
   bit         err_q[$];
   logic [8:0] out_log[$];
   int         cur_n = 0;
   logic [7:0] cur_k, cur_len, cur_sum;
   int         mdl_cnt = 0;
   int         err_seen = 0;
   bit         prev_stall = 0;
   bit         prev_valid = 0;
   logic [7:0] prev_data;
   logic       prev_last;
   bit         run = 0;
   bit         rand_rdy = 0;

   always @(negedge clk) begin
      bit         new_beat;
      bit         exp_err;
      logic [8:0] e;
      logic [7:0] b;
      int         nsat;
      if (run) begin
         if (prev_stall) begin
            chk("hold_valid", 32'(m_tvalid), 32'd1);
            chk("hold_data", 32'(m_tdata), 32'(prev_data));
            chk("hold_last", 32'(m_tlast), 32'(prev_last));
         end
         new_beat = m_tvalid && !prev_stall;
         exp_err = 0;
         if (new_beat && m_tlast) begin
            mdl_cnt++;
            if (err_q.size() > 0) exp_err = err_q.pop_front();
         end
         if (pkt_err) err_seen++;
         chk("pkt_err", 32'(pkt_err), 32'(exp_err));
         chk("pkt_count", 32'(pkt_count), 32'(mdl_cnt));
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'(m_tvalid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("m_tdata", 32'(m_tdata), 32'(e[7:0]));
               chk("m_tlast", 32'(m_tlast), 32'(e[8]));
               out_log.push_back({m_tlast, m_tdata});
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
         if (s_tvalid && s_tready && !rst) begin
            if (cur_n == 0) begin
               cur_k   = packet_config[7:0];
               cur_len = packet_config[15:8];
               cur_sum = 8'd0;
            end
            b = s_tdata + cur_k;
            exp_q.push_back({1'b0, b});
            cur_sum = cur_sum + b;
            cur_n++;
            if (s_tlast) begin
               exp_q.push_back({1'b1, cur_sum});
               nsat = (cur_n > 255) ? 255 : cur_n;
               err_q.push_back(cur_len != 0 && nsat != int'(cur_len));
               cur_n = 0;
            end
         end
         if (rst) begin
            exp_q.delete();
            err_q.delete();
            cur_n = 0;
            mdl_cnt = 0;
            prev_stall = 0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_rdy) m_tready = 1'($urandom % 2);
   end

   // Caller is positioned 1 time unit after a rising edge.
   task automatic send_beat(input logic [7:0] d, input logic l);
      int n = 0;
      s_tdata  = d;
      s_tvalid = 1'b1;
      s_tlast  = l;
      @(negedge clk);
      while (!s_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_tready) begin
         miscompares++;
         $display("FAIL send_timeout: s_tready=%0b required 1", s_tready);
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || m_tvalid) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout: %0d beats left required 0",
                  exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_log(input string nm, input logic [8:0] e[$]);
      chk({nm, "_len"}, 32'(out_log.size()), 32'(e.size()));
      for (int i = 0; i < e.size() && i < out_log.size(); i++)
         chk(nm, 32'(out_log[i]), 32'(e[i]));
      out_log.delete();
   endtask

   initial begin
      logic [8:0] el[$];
      int         e0;
      int         n;
      rst = 1'b1;
      s_tdata = 8'd0;
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      m_tready = 1'b1;
      packet_config = 16'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_m_tdata", 32'(m_tdata), 32'd0);
      chk("rst_m_tlast", 32'(m_tlast), 32'd0);
      chk("rst_pkt_err", 32'(pkt_err), 32'd0);
      chk("rst_pkt_count", 32'(pkt_count), 32'd0);
      chk("rst_s_tready", 32'(s_tready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run = 1'b1;

      // len=4 k=1
      packet_config = {8'd4, 8'd1};
      send_beat(8'd10, 0);
      send_beat(8'd20, 0);
      send_beat(8'd30, 0);
      send_beat(8'd40, 1);
      drain();
      el = '{9'h00B, 9'h015, 9'h01F, 9'h029, 9'h168};
      chk_log("t1_out", el);
      chk("t1_err", 32'(err_seen), 32'd0);
      chk("t1_count", 32'(pkt_count), 32'd1);

      // single beat with wrap
      packet_config = {8'd1, 8'h10};
      send_beat(8'hF8, 1);
      drain();
      el = '{9'h008, 9'h108};
      chk_log("t2_out", el);
      chk("t2_count", 32'(pkt_count), 32'd2);

      // short packet with and without length check
      e0 = err_seen;
      packet_config = {8'd3, 8'd0};
      send_beat(8'd5, 0);
      send_beat(8'd6, 1);
      drain();
      el = '{9'h005, 9'h006, 9'h10B};
      chk_log("t3_out", el);
      chk("t3_err_pulse", 32'(err_seen - e0), 32'd1);
      e0 = err_seen;
      packet_config = {8'd0, 8'd0};
      send_beat(8'd5, 0);
      send_beat(8'd6, 1);
      drain();
      chk("t3_no_pulse", 32'(err_seen - e0), 32'd0);
      out_log.delete();

      // config change mid-packet
      packet_config = {8'd4, 8'd1};
      send_beat(8'd1, 0);
      packet_config = {8'd4, 8'd7};
      send_beat(8'd2, 0);
      send_beat(8'd3, 0);
      send_beat(8'd4, 1);
      send_beat(8'd0, 1);
      drain();
      el = '{9'h002, 9'h003, 9'h004, 9'h005, 9'h10E, 9'h007, 9'h107};
      chk_log("t4_out", el);

      // reset mid-packet
      packet_config = {8'd4, 8'd0};
      send_beat(8'd1, 0);
      send_beat(8'd2, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("t5_count", 32'(pkt_count), 32'd0);
      @(posedge clk);
      #1;
      out_log.delete();
      send_beat(8'd9, 1);
      drain();
      el = '{9'h009, 9'h109};
      chk_log("t5_out", el);
      chk("t5_count2", 32'(pkt_count), 32'd1);

      // random backpressure over 20 packets
      rand_rdy = 1'b1;
      for (int p = 0; p < 20; p++) begin
         n = $urandom_range(1, 6);
         packet_config = {8'($urandom_range(0, 6)), 8'($urandom)};
         for (int i = 0; i < n; i++)
            send_beat(8'($urandom), (i == n - 1));
         if ($urandom % 3 == 0) begin
            @(posedge clk);
            #1;
         end
      end
      drain();
      rand_rdy = 1'b0;
      m_tready = 1'b1;
      drain();
      chk("t6_count", 32'(pkt_count), 32'd21);

      $display("== %0d vectors applied, %0d miscompares ==", vectors,
               miscompares);
      $finish;
   end

endmodule
